perceptron_predictor_gh: RTL

- Parametrised global-history perceptron branch predictor with independent predict and train ports.
- Supports registered valid/ready handshakes, saturating signed weights, speculative global history with mispredict recovery, and a table-clear state machine after reset.
- Sits between fetch (predict port) and branch resolution (update port) in the core testbench.

---
 rtl/perceptron_pkg.sv | 16 +
 rtl/perceptron_dot.sv | 26 ++
 rtl/perceptron_predictor_gh.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/perceptron_pkg.sv
// Shared types and helpers for the global-history perceptron predictor.
package perceptron_pkg;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  function automatic int theta_default(input int hist_len);
    return (193 * hist_len) / 100 + 14;
  endfunction

  // Symmetric saturation keeps -2^(W-1) unreachable so weights stay sign-balanced.
  function automatic int sat_step(input int w, input logic inc, input int wmax);
    if (inc) return (w >= wmax) ? wmax : w + 1;
    return (w <= -wmax) ? -wmax : w - 1;
  endfunction

endpackage

// File: rtl/perceptron_dot.sv
// Combinational signed dot product of one weight row against +/-1 history inputs.
module perceptron_dot #(
  parameter int HIST_LEN = 32,
  parameter int WEIGHT_W = 8,
  parameter int SUM_W    = 15
) (
  input  logic [HIST_LEN*WEIGHT_W-1:0] weights,
  input  logic [HIST_LEN-1:0]          hist,
  input  logic [WEIGHT_W-1:0]          bias,
  output logic signed [SUM_W-1:0]      sum
);

  logic [SUM_W-1:0] acc;
  logic [SUM_W-1:0] term;

  always_comb begin
    acc  = {{(SUM_W-WEIGHT_W){bias[WEIGHT_W-1]}}, bias};
    term = '0;
    for (int i = 0; i < HIST_LEN; i++) begin
      term = {{(SUM_W-WEIGHT_W){weights[i*WEIGHT_W+WEIGHT_W-1]}}, weights[i*WEIGHT_W +: WEIGHT_W]};
      acc  = hist[i] ? acc + term : acc - term;
    end
    sum = acc;
  end

endmodule

// File: rtl/perceptron_predictor_gh.sv
// Global-history perceptron branch predictor with table clear after reset.
// Optional per-row bias weight enabled by defining PERCEPTRON_BIAS_EN.
module perceptron_predictor_gh
  import perceptron_pkg::*;
#(
  parameter int ADDR_W   = 64,
  parameter int NUM_ROWS = 64,
  parameter int HIST_LEN = 32,
  parameter int WEIGHT_W = 8,
  parameter int THETA    = theta_default(HIST_LEN),
  parameter int IDX_W    = $clog2(NUM_ROWS),
  parameter int SUM_W    = WEIGHT_W + $clog2(HIST_LEN + 2) + 1
) (
  input  logic                clk,
  input  logic                rst,
  output logic                init_done,
  input  logic                pred_req,
  output logic                pred_ready,
  input  logic [ADDR_W-1:0]   pred_pc,
  output logic                pred_valid,
  output logic                pred_taken,
  output logic [SUM_W-1:0]    pred_sum,
  output logic [HIST_LEN-1:0] pred_ghist,
  input  logic                upd_valid,
  output logic                upd_ready,
  input  logic [ADDR_W-1:0]   upd_pc,
  input  logic                upd_taken,
  input  logic [SUM_W-1:0]    upd_sum,
  input  logic [HIST_LEN-1:0] upd_ghist
);

  localparam int WMAX  = (1 << (WEIGHT_W - 1)) - 1;
  localparam int ROW_W = HIST_LEN * WEIGHT_W;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [HIST_LEN-1:0]     ghist;
  logic [ROW_W-1:0]        wt [NUM_ROWS];
  logic [IDX_W-1:0]        pred_idx, upd_idx;
  logic                    run, upd_acc, pred_acc, upd_pred, mispred, in_band, train;
  logic signed [SUM_W-1:0] upd_sum_s, dot_sum;
  logic                    dot_taken;
  logic [ROW_W-1:0]        upd_row, new_row;
  logic [WEIGHT_W-1:0]     pred_bias;
  int                      step;
  logic                    unused_pc;

  assign unused_pc = ^{pred_pc[ADDR_W-1:IDX_W+2], pred_pc[1:0], upd_pc[ADDR_W-1:IDX_W+2], upd_pc[1:0]};

  assign run       = (state_q == ST_RUN);
  assign pred_idx  = pred_pc[IDX_W+1:2] ^ ghist[IDX_W-1:0];
  assign upd_idx   = upd_pc[IDX_W+1:2] ^ upd_ghist[IDX_W-1:0];
  assign upd_sum_s = upd_sum;
  assign upd_pred  = ~upd_sum_s[SUM_W-1];
  assign upd_acc   = upd_valid && run;
  assign mispred   = upd_acc && (upd_pred != upd_taken);
  assign in_band   = (int'(upd_sum_s) >= -THETA) && (int'(upd_sum_s) <= THETA);
  assign train     = upd_acc && (mispred || in_band);
  assign pred_acc  = pred_req && pred_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    init_done  = 1'b0;
    upd_ready  = 1'b0;
    pred_ready = 1'b0;
    case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == IDX_W'(NUM_ROWS - 1)) state_d = ST_RUN;
      end
      default: begin
        init_done  = 1'b1;
        upd_ready  = 1'b1;
        // A recovering update owns the history this cycle.
        pred_ready = ~mispred;
      end
    endcase
  end

`ifdef PERCEPTRON_BIAS_EN
  logic [WEIGHT_W-1:0] bias [NUM_ROWS];
  int                  bias_step;

  assign pred_bias = bias[pred_idx];
  assign bias_step = sat_step(int'($signed(bias[upd_idx])), upd_taken, WMAX);

  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) bias[ptr_q] <= '0;
    else if (train)         bias[upd_idx] <= bias_step[WEIGHT_W-1:0];
  end
`else
  assign pred_bias = '0;
`endif

  perceptron_dot #(
    .HIST_LEN (HIST_LEN),
    .WEIGHT_W (WEIGHT_W),
    .SUM_W    (SUM_W)
  ) u_dot (
    .weights (wt[pred_idx]),
    .hist    (ghist),
    .bias    (pred_bias),
    .sum     (dot_sum)
  );

  assign dot_taken = ~dot_sum[SUM_W-1];

  always_comb begin
    upd_row = wt[upd_idx];
    new_row = upd_row;
    step    = 0;
    for (int i = 0; i < HIST_LEN; i++) begin
      step = sat_step(int'($signed(upd_row[i*WEIGHT_W +: WEIGHT_W])), upd_ghist[i] == upd_taken, WMAX);
      new_row[i*WEIGHT_W +: WEIGHT_W] = step[WEIGHT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) wt[ptr_q] <= '0;
    else if (train)         wt[upd_idx] <= new_row;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghist      <= '0;
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_sum   <= '0;
      pred_ghist <= '0;
    end else begin
      pred_valid <= pred_acc;
      if (pred_acc) begin
        pred_taken <= dot_taken;
        pred_sum   <= dot_sum;
        pred_ghist <= ghist;
      end
      if (mispred)       ghist <= {upd_ghist[HIST_LEN-2:0], upd_taken};
      else if (pred_acc) ghist <= {ghist[HIST_LEN-2:0], dot_taken};
    end
  end

endmodule
